// File: rtl/alu_serial_rx_if.sv
// Record channel from the serial receiver to the ALU core (valid/ready).
// master drives the record, slave returns out_ready.
interface alu_serial_rx_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic [2:0]  out_err;

    modport master (
        output out_valid,
        output out_a,
        output out_b,
        output out_op,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_a,
        input  out_b,
        input  out_op,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/alu_serial_rx.sv
// Purpose: deserialise 11-bit frames into an ALU operand packet, CRC4/length/opcode check.
// Latency: out_valid rises 2 clk after the cmd frame's stop bit is sampled.
// Backpressure: one record held until out_valid&&out_ready; a packet finishing while held is dropped (overrun).
module alu_serial_rx #(
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sin,
    alu_serial_rx_if.master rec,
    output logic            frame_err,
    output logic            overrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BITS = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  err;
    } rec_t;

    logic [1:0]    state;
    logic [3:0]    bit_cnt;
    logic          is_cmd;
    logic [7:0]    shreg;
    logic [63:0]   data_buf;
    logic [3:0]    byte_cnt;
    logic [TW-1:0] idle_cnt;

    logic          pkt_vld;
    logic [63:0]   pkt_buf;
    logic [3:0]    pkt_cnt;
    logic [2:0]    pkt_op;
    logic [3:0]    pkt_crc;

    logic          res_vld;
    rec_t          res;
    rec_t          chk;
    logic          op_ok;

    // Serial CRC4, x^4+x+1, init 0, MSB first.
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            is_cmd    <= 1'b0;
            shreg     <= '0;
            data_buf  <= '0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            frame_err <= 1'b0;
            pkt_vld   <= 1'b0;
            pkt_buf   <= '0;
            pkt_cnt   <= '0;
            pkt_op    <= '0;
            pkt_crc   <= '0;
        end else begin
            frame_err <= 1'b0;
            pkt_vld   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!sin) begin
                        state    <= S_BITS;
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                    end else if (byte_cnt != 4'd0) begin
                        // Abandon a stalled partial packet.
                        if (idle_cnt == IDLE_LAST) begin
                            byte_cnt <= '0;
                            data_buf <= '0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                S_BITS: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd0) begin
                        is_cmd <= sin;
                    end else if (bit_cnt != 4'd9) begin
                        shreg <= {shreg[6:0], sin};
                    end else begin
                        bit_cnt <= '0;
                        if (!sin) begin
                            frame_err <= 1'b1;
                            byte_cnt  <= '0;
                            data_buf  <= '0;
                            state     <= S_HOLD;
                        end else begin
                            state <= S_IDLE;
                            if (is_cmd) begin
                                pkt_vld  <= 1'b1;
                                pkt_buf  <= data_buf;
                                pkt_cnt  <= byte_cnt;
                                pkt_op   <= shreg[6:4];
                                pkt_crc  <= shreg[3:0];
                                byte_cnt <= '0;
                                data_buf <= '0;
                            end else begin
                                data_buf <= {data_buf[55:0], shreg};
                                if (byte_cnt != 4'd9)
                                    byte_cnt <= byte_cnt + 4'd1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    // A broken line may sit low; only a high level re-arms start detection.
                    if (sin)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        op_ok = (pkt_op == 3'b000) || (pkt_op == 3'b001) ||
                (pkt_op == 3'b100) || (pkt_op == 3'b101);
        chk    = '0;
        chk.op = pkt_op;
        if (pkt_cnt != 4'd8)
            chk.err = ERR_DATA;
        else if (crc4({pkt_buf, 1'b1, pkt_op}) != pkt_crc)
            chk.err = ERR_CRC;
        else if (!op_ok)
            chk.err = ERR_OP;
        else begin
            chk.a = pkt_buf[31:0];
            chk.b = pkt_buf[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld       <= 1'b0;
            res           <= '0;
            overrun       <= 1'b0;
            rec.out_valid <= 1'b0;
            rec.out_a     <= '0;
            rec.out_b     <= '0;
            rec.out_op    <= '0;
            rec.out_err   <= '0;
        end else begin
            overrun <= 1'b0;
            res_vld <= pkt_vld;
            if (pkt_vld)
                res <= chk;
            if (rec.out_valid && rec.out_ready)
                rec.out_valid <= 1'b0;
            // Only an empty output slot takes a new record; ready never feeds valid.
            if (res_vld) begin
                if (rec.out_valid) begin
                    overrun <= 1'b1;
                end else begin
                    rec.out_valid <= 1'b1;
                    rec.out_a     <= res.a;
                    rec.out_b     <= res.b;
                    rec.out_op    <= res.op;
                    rec.out_err   <= res.err;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed + randomized bench for alu_serial_rx with a packet-level reference model.
module tb_alu_serial_rx;
    localparam int TO = 40;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  err;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    logic sin;
    logic frame_err;
    logic overrun;

    alu_serial_rx_if rec_if();

    alu_serial_rx #(.IDLE_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .rec       (rec_if),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vld_cnt = 0;
    logic [7:0] pkt[$];

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rec_t cur();
        rec_t r;
        r.a   = rec_if.out_a;
        r.b   = rec_if.out_b;
        r.op  = rec_if.out_op;
        r.err = rec_if.out_err;
        return r;
    endfunction

    // CRC as the remainder of msg * x^4 divided by x^4+x+1.
    function automatic logic [3:0] crc_model(input logic [67:0] msg);
        logic [71:0] m;
        m = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (m[i]) m[i-:5] = m[i-:5] ^ 5'b10011;
        return m[3:0];
    endfunction

    function automatic logic [63:0] pkt_words();
        logic [63:0] w;
        w = '0;
        if (pkt.size() == 8)
            for (int i = 0; i < 8; i++) w = {w[55:0], pkt[i]};
        return w;
    endfunction

    function automatic logic [3:0] good_crc(input logic [2:0] op);
        return crc_model({pkt_words(), 1'b1, op});
    endfunction

    function automatic rec_t model(input logic [2:0] op, input logic [3:0] crc);
        rec_t r;
        logic [63:0] w;
        r    = '0;
        r.op = op;
        w    = pkt_words();
        if (pkt.size() != 8)
            r.err = 3'b100;
        else if (crc_model({w, 1'b1, op}) != crc)
            r.err = 3'b010;
        else if (!(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5))
            r.err = 3'b001;
        else begin
            r.b = w[63:32];
            r.a = w[31:0];
        end
        return r;
    endfunction

    // One clock; also checks that a stalled record stays put.
    task automatic tick();
        logic pv, pr, pst;
        rec_t pc;
        pv  = rec_if.out_valid;
        pr  = rec_if.out_ready;
        pst = rst;
        pc  = cur();
        @(posedge clk);
        #1;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rec_if.out_valid) vld_cnt++;
        if (pv && !pr && !pst) begin
            check("hold_vld", 70'(rec_if.out_valid), 70'(1));
            check("hold_rec", cur(), pc);
        end
    endtask

    task automatic send_frame(input logic cmd, input logic [7:0] d, input logic stop);
        sin = 1'b0; tick();
        sin = cmd;  tick();
        for (int i = 7; i >= 0; i--) begin
            sin = d[i];
            tick();
        end
        sin = stop; tick();
        sin = 1'b1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [3:0] crc);
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    // Called right after the cmd stop-bit edge; checks latency, contents and release.
    task automatic expect_rec(input string tag, input rec_t exp);
        tick();
        check({tag, "_lat1"}, 70'(rec_if.out_valid), 70'(0));
        tick();
        check({tag, "_lat2"}, 70'(rec_if.out_valid), 70'(1));
        check({tag, "_rec"}, cur(), exp);
        tick();
        check({tag, "_rel"}, 70'(rec_if.out_valid), 70'(0));
    endtask

    task automatic run_pkt(input string tag, input logic [2:0] op, input logic [3:0] crc_x, input int gap);
        logic [3:0] crc;
        crc = good_crc(op) ^ crc_x;
        foreach (pkt[i]) begin
            send_frame(1'b0, pkt[i], 1'b1);
            repeat (gap) tick();
        end
        send_cmd(op, crc);
        expect_rec(tag, model(op, crc));
    endtask

    task automatic quiet(input string tag, input int n);
        int v0;
        v0 = vld_cnt;
        repeat (n) tick();
        check(tag, 70'(vld_cnt - v0), 70'(0));
    endtask

    task automatic rand_pkt(input int n);
        pkt.delete();
        repeat (n) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        rec_t exp1;
        logic [3:0] crc;
        int f0, o0, n;

        rst = 1'b1;
        sin = 1'b0;
        rec_if.out_ready = 1'b1;
        tick();
        sin = 1'b1; tick();
        sin = 1'b0; tick();
        check("rst_vld", 70'(rec_if.out_valid), 70'(0));
        check("rst_rec", cur(), '0);
        check("rst_fe", 70'(frame_err), 70'(0));
        check("rst_ov", 70'(overrun), 70'(0));
        rst = 1'b0;
        sin = 1'b1;
        quiet("rst_quiet", 5);

        pkt = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
        run_pkt("add_ok", 3'b100, 4'h0, 0);
        run_pkt("add_crc", 3'b100, 4'h1, 0);
        run_pkt("op_bad", 3'b011, 4'h0, 1);

        rand_pkt(7);
        run_pkt("len7", 3'b100, 4'h5, 0);
        rand_pkt(9);
        run_pkt("len9", 3'b000, 4'h0, 0);
        rand_pkt(24);
        run_pkt("len24", 3'b001, 4'h0, 0);
        pkt.delete();
        run_pkt("len0", 3'b101, 4'h0, 0);

        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(0, 9);
            rand_pkt(n == 0 ? 7 : (n == 1 ? 9 : 8));
            run_pkt("rand", 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                    $urandom_range(0, 5));
            repeat ($urandom_range(0, 4)) tick();
        end

        // Stalled output: second packet must be dropped with a single overrun pulse.
        rand_pkt(8);
        crc  = good_crc(3'b001);
        exp1 = model(3'b001, crc);
        rec_if.out_ready = 1'b0;
        foreach (pkt[i]) send_frame(1'b0, pkt[i], 1'b1);
        send_cmd(3'b001, crc);
        tick(); tick();
        check("ovr_first_vld", 70'(rec_if.out_valid), 70'(1));
        check("ovr_first_rec", cur(), exp1);
        o0 = ov_cnt;
        rand_pkt(8);
        foreach (pkt[i]) send_frame(1'b0, pkt[i], 1'b1);
        send_cmd(3'b100, good_crc(3'b100));
        repeat (4) tick();
        check("ovr_pulses", 70'(ov_cnt - o0), 70'(1));
        check("ovr_held_rec", cur(), exp1);
        rec_if.out_ready = 1'b1;
        tick();
        check("ovr_release", 70'(rec_if.out_valid), 70'(0));
        quiet("ovr_lost", 20);

        // Bad stop bit on byte 3 with the line held low afterwards.
        f0 = fe_cnt;
        send_frame(1'b0, 8'h11, 1'b1);
        send_frame(1'b0, 8'h22, 1'b1);
        send_frame(1'b0, 8'h33, 1'b0);
        sin = 1'b0;
        repeat (3) tick();
        sin = 1'b1;
        quiet("fe_quiet", 3);
        check("fe_pulses", 70'(fe_cnt - f0), 70'(1));
        rand_pkt(8);
        run_pkt("fe_next", 3'b101, 4'h0, 0);

        // Idle timeout boundary: TO-1 idle cycles keep the partial packet, TO discards it.
        rand_pkt(8);
        crc = good_crc(3'b000);
        for (int i = 0; i < 4; i++) send_frame(1'b0, pkt[i], 1'b1);
        repeat (TO - 1) tick();
        for (int i = 4; i < 8; i++) send_frame(1'b0, pkt[i], 1'b1);
        send_cmd(3'b000, crc);
        expect_rec("to_keep", model(3'b000, crc));

        rand_pkt(3);
        foreach (pkt[i]) send_frame(1'b0, pkt[i], 1'b1);
        quiet("to_quiet", TO);
        rand_pkt(8);
        run_pkt("to_drop", 3'b100, 4'h0, 0);

        // Reset in the middle of a frame of a partial packet.
        rand_pkt(4);
        foreach (pkt[i]) send_frame(1'b0, pkt[i], 1'b1);
        sin = 1'b0; tick();
        sin = 1'b1; tick();
        sin = 1'b0; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        sin = 1'b1;
        quiet("rst_mid_quiet", 30);
        rand_pkt(8);
        run_pkt("rst_mid_next", 3'b001, 4'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
